// File: rtl/cmd_ctrl_rx_gen.sv
// -----------------------------------------------------------------------------
// cmd_ctrl_rx_gen
// Receive-side command controller (second generation). Decodes framed command
// byte sequences from the UART RX deserialiser into register-file write/read
// strobes and ALU operations. All outputs are registered.
//
// Ports:
//   CLK            system clock
//   RST            asynchronous active-low reset
//   Data_valid     RX byte valid (level, held >= 1 cycle per byte)
//   P_Data_RX      received byte
//   ALU_OUT_Valid  ALU result valid
//   ALU_EN         one-cycle ALU start strobe
//   CLK_EN         ALU clock-gate enable
//   WrEn           one-cycle register-file write strobe
//   RdEn           one-cycle register-file read strobe
//   ALU_FUN        ALU function code (held while waiting for the ALU)
//   Address        register-file address
//   WrData         register-file write data
//   Busy           high whenever the FSM is not idle
//   Frame_Err      one-cycle pulse on protocol error or inter-byte timeout
// -----------------------------------------------------------------------------
module cmd_ctrl_rx_gen #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 4,
    parameter int unsigned       FUN_W       = 4,
    parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
    parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB,
    parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD,
    parameter logic [DATA_W-1:0] CMD_BWR     = 8'hEE,
    parameter int unsigned       OPA_ADDR    = 0,
    parameter int unsigned       OPB_ADDR    = 1,
    parameter int unsigned       TIMEOUT     = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Data_valid,
    input  logic [DATA_W-1:0] P_Data_RX,
    input  logic              ALU_OUT_Valid,
    output logic              ALU_EN,
    output logic              CLK_EN,
    output logic              WrEn,
    output logic              RdEn,
    output logic [FUN_W-1:0]  ALU_FUN,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    output logic              Busy,
    output logic              Frame_Err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_BW_ADDR  = 4'd4;
    localparam logic [3:0] ST_BW_CNT   = 4'd5;
    localparam logic [3:0] ST_BW_DATA  = 4'd6;
    localparam logic [3:0] ST_ALU_A    = 4'd7;
    localparam logic [3:0] ST_ALU_B    = 4'd8;
    localparam logic [3:0] ST_ALU_F    = 4'd9;
    localparam logic [3:0] ST_ALU_WAIT = 4'd10;

    // Control state
    logic [3:0]        state_q, state_d;
    logic              dv_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    // Registered outputs
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              alu_en_q, alu_en_d;
    logic              clk_en_q, clk_en_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic accept;
    logic accept_eff;
    logic progress;
    logic timeout_hit;
    logic abort;

    function automatic logic is_alu_state(input logic [3:0] s);
        return (s == ST_ALU_A) || (s == ST_ALU_B) || (s == ST_ALU_F) || (s == ST_ALU_WAIT);
    endfunction

    // Rising edge of Data_valid: a held level is only ever counted once.
    assign accept = Data_valid & ~dv_q;

    // Bytes arriving while waiting for the ALU are dropped silently.
    assign accept_eff = accept && (state_q != ST_ALU_WAIT);

    // Anything that moves the frame forward beats a simultaneous timeout.
    assign progress = accept_eff || ((state_q == ST_ALU_WAIT) && ALU_OUT_Valid);

    assign timeout_hit = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT));
    assign abort       = timeout_hit && !progress;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        err_d     = 1'b0;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_eff) begin
                    // if-chain rather than case: opcode parameters may legally collide
                    if (P_Data_RX == CMD_WR) begin
                        state_d = ST_WR_ADDR;
                    end else if (P_Data_RX == CMD_RD) begin
                        state_d = ST_RD_ADDR;
                    end else if (P_Data_RX == CMD_BWR) begin
                        state_d = ST_BW_ADDR;
                    end else if (P_Data_RX == CMD_ALU_OP) begin
                        state_d = ST_ALU_A;
                    end else if (P_Data_RX == CMD_ALU_NOP) begin
                        state_d = ST_ALU_F;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WR_ADDR: begin
                if (accept_eff) begin
                    addr_d  = P_Data_RX[ADDR_W-1:0];
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (accept_eff) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wr_data_d = P_Data_RX;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (accept_eff) begin
                    rd_en_d   = 1'b1;
                    address_d = P_Data_RX[ADDR_W-1:0];
                    state_d   = ST_IDLE;
                end
            end
            ST_BW_ADDR: begin
                if (accept_eff) begin
                    addr_d  = P_Data_RX[ADDR_W-1:0];
                    state_d = ST_BW_CNT;
                end
            end
            ST_BW_CNT: begin
                if (accept_eff) begin
                    if (P_Data_RX == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = P_Data_RX;
                        state_d = ST_BW_DATA;
                    end
                end
            end
            ST_BW_DATA: begin
                if (accept_eff) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wr_data_d = P_Data_RX;
                    addr_d    = addr_q + ADDR_W'(1);  // wraps at 2^ADDR_W
                    cnt_d     = cnt_q - DATA_W'(1);
                    if (cnt_q == DATA_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ALU_A: begin
                if (accept_eff) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_W'(OPA_ADDR);
                    wr_data_d = P_Data_RX;
                    state_d   = ST_ALU_B;
                end
            end
            ST_ALU_B: begin
                if (accept_eff) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_W'(OPB_ADDR);
                    wr_data_d = P_Data_RX;
                    state_d   = ST_ALU_F;
                end
            end
            ST_ALU_F: begin
                if (accept_eff) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = P_Data_RX[FUN_W-1:0];
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                alu_fun_d = alu_fun_q;
                if (ALU_OUT_Valid) begin
                    state_d   = ST_IDLE;
                    alu_fun_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout abort: no strobe can be pending here since nothing was accepted.
        if (abort) begin
            state_d   = ST_IDLE;
            err_d     = 1'b1;
            alu_fun_d = '0;
        end

        // Timer runs only while a frame is open and nothing moves it forward.
        if ((state_q == ST_IDLE) || (state_d != state_q) || accept_eff) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        // Gate opens with the ALU opcode and stays on one cycle past ALU_WAIT
        // so the ALU can finish its result cycle; a timeout closes it at once.
        clk_en_d = !abort && (is_alu_state(state_d) || is_alu_state(state_q));
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            dv_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            alu_fun_q <= '0;
            address_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            dv_q      <= Data_valid;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            alu_fun_q <= alu_fun_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ALU_EN    = alu_en_q;
    assign CLK_EN    = clk_en_q;
    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign ALU_FUN   = alu_fun_q;
    assign Address   = address_q;
    assign WrData    = wr_data_q;
    assign Busy      = busy_q;
    assign Frame_Err = err_q;

endmodule

// File: tb/tb_cmd_ctrl_rx_gen.sv
// -----------------------------------------------------------------------------
// tb_cmd_ctrl_rx_gen
// Directed self-checking bench for cmd_ctrl_rx_gen (TIMEOUT overridden to 16).
// A negedge logger records every strobe; scenario tasks compare the log and
// sampled outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cmd_ctrl_rx_gen;

    logic       CLK;
    logic       RST;
    logic       Data_valid;
    logic [7:0] P_Data_RX;
    logic       ALU_OUT_Valid;
    logic       ALU_EN;
    logic       CLK_EN;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] ALU_FUN;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic       Busy;
    logic       Frame_Err;

    int n_vec;
    int n_err;

    logic [11:0] wr_log[$];   // {Address, WrData}
    logic [3:0]  rd_log[$];
    logic [3:0]  alu_log[$];
    int          err_cnt;
    int          excl_viol;

    cmd_ctrl_rx_gen #(
        .TIMEOUT(16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Data_valid   (Data_valid),
        .P_Data_RX    (P_Data_RX),
        .ALU_OUT_Valid(ALU_OUT_Valid),
        .ALU_EN       (ALU_EN),
        .CLK_EN       (CLK_EN),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .ALU_FUN      (ALU_FUN),
        .Address      (Address),
        .WrData       (WrData),
        .Busy         (Busy),
        .Frame_Err    (Frame_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST) begin
            if (WrEn) wr_log.push_back({Address, WrData});
            if (RdEn) rd_log.push_back(Address);
            if (ALU_EN) alu_log.push_back(ALU_FUN);
            if (Frame_Err) err_cnt++;
            if (int'(WrEn) + int'(RdEn) + int'(ALU_EN) > 1) excl_viol++;
        end
    end

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        alu_log.delete();
        err_cnt = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after one low cycle.
    task automatic send_byte(input logic [7:0] b, input int hold);
        P_Data_RX  = b;
        Data_valid = 1'b1;
        repeat (hold) @(posedge CLK);
        #1 Data_valid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        RST = 1'b0;
        Data_valid = 1'b0;
        P_Data_RX = 8'h00;
        ALU_OUT_Valid = 1'b0;
        err_cnt = 0;
        excl_viol = 0;
        repeat (3) @(posedge CLK);
        #1;
        outs = {ALU_EN, CLK_EN, WrEn, RdEn, ALU_FUN, Address, WrData, Busy, Frame_Err};
        n_vec++;
        if (outs !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        RST = 1'b1;
        idle_cycles(2);
        n_vec++;
        if (Busy !== 1'b0 || Frame_Err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: Busy=%b Frame_Err=%b expected 0/0", Busy, Frame_Err);
        end
    endtask

    task automatic test_single_write();
        clear_logs();
        send_byte(8'hAA, 3);
        send_byte(8'h05, 3);
        n_vec++;
        if (Busy !== 1'b1) begin
            n_err++;
            $display("FAIL wr_busy_mid: got %b expected 1", Busy);
        end
        send_byte(8'h3C, 3);
        idle_cycles(3);
        n_vec++;
        if (wr_log.size() != 1 || wr_log[0] !== 12'h53C) begin
            n_err++;
            $display("FAIL single_write: got %0d writes first %h expected 1 write 53c",
                     wr_log.size(), wr_log.size() ? wr_log[0] : 12'h0);
        end
        n_vec++;
        if (Busy !== 1'b0 || err_cnt != 0 || rd_log.size() != 0) begin
            n_err++;
            $display("FAIL single_write_after: Busy=%b errs=%0d reads=%0d expected 0/0/0",
                     Busy, err_cnt, rd_log.size());
        end
    endtask

    task automatic test_read_long();
        clear_logs();
        send_byte(8'hBB, 10);
        send_byte(8'h0A, 10);
        idle_cycles(2);
        n_vec++;
        if (rd_log.size() != 1 || rd_log[0] !== 4'hA) begin
            n_err++;
            $display("FAIL read_long: got %0d reads first %h expected 1 read a",
                     rd_log.size(), rd_log.size() ? rd_log[0] : 4'h0);
        end
        n_vec++;
        if (wr_log.size() != 0 || err_cnt != 0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL read_side_effects: writes=%0d errs=%0d Busy=%b expected 0/0/0",
                     wr_log.size(), err_cnt, Busy);
        end
    endtask

    task automatic test_burst();
        logic [11:0] exp_wr[3];
        exp_wr[0] = 12'hE11;
        exp_wr[1] = 12'hF22;
        exp_wr[2] = 12'h033;
        clear_logs();
        send_byte(8'hEE, 1);
        send_byte(8'h0E, 1);
        send_byte(8'h03, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        idle_cycles(2);
        n_vec++;
        if (wr_log.size() != 3) begin
            n_err++;
            $display("FAIL burst_count: got %0d writes expected 3", wr_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (wr_log[i] !== exp_wr[i]) begin
                    n_err++;
                    $display("FAIL burst_write%0d: got %h expected %h", i, wr_log[i], exp_wr[i]);
                end
            end
        end
        n_vec++;
        if (Busy !== 1'b0 || err_cnt != 0) begin
            n_err++;
            $display("FAIL burst_end: Busy=%b errs=%0d expected 0/0", Busy, err_cnt);
        end
        clear_logs();
        send_byte(8'hEE, 1);
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        idle_cycles(2);
        n_vec++;
        if (err_cnt != 1 || wr_log.size() != 0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst_zero: errs=%0d writes=%0d Busy=%b expected 1/0/0",
                     err_cnt, wr_log.size(), Busy);
        end
    endtask

    task automatic test_alu();
        int clk_en_low;
        clear_logs();
        clk_en_low = 0;
        send_byte(8'hCC, 1);
        send_byte(8'h07, 1);
        send_byte(8'h09, 1);
        n_vec++;
        if (CLK_EN !== 1'b1 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL alu_operand_phase: CLK_EN=%b Busy=%b expected 1/1", CLK_EN, Busy);
        end
        P_Data_RX  = 8'h02;
        Data_valid = 1'b1;
        @(posedge CLK);
        #1 Data_valid = 1'b0;
        n_vec++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h2) begin
            n_err++;
            $display("FAIL alu_start: ALU_EN=%b ALU_FUN=%h expected 1/2", ALU_EN, ALU_FUN);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            if (CLK_EN !== 1'b1) clk_en_low++;
        end
        n_vec++;
        if (clk_en_low != 0 || ALU_FUN !== 4'h2 || ALU_EN !== 1'b0) begin
            n_err++;
            $display("FAIL alu_wait: clk_en_low=%0d ALU_FUN=%h ALU_EN=%b expected 0/2/0",
                     clk_en_low, ALU_FUN, ALU_EN);
        end
        @(posedge CLK);
        #1 ALU_OUT_Valid = 1'b1;
        @(posedge CLK);
        #1 ALU_OUT_Valid = 1'b0;
        n_vec++;
        if (Busy !== 1'b0 || ALU_FUN !== 4'h0) begin
            n_err++;
            $display("FAIL alu_done: Busy=%b ALU_FUN=%h expected 0/0", Busy, ALU_FUN);
        end
        idle_cycles(2);
        n_vec++;
        if (CLK_EN !== 1'b0) begin
            n_err++;
            $display("FAIL alu_clk_en_off: got %b expected 0", CLK_EN);
        end
        n_vec++;
        if (wr_log.size() != 2 || wr_log[0] !== 12'h007 || wr_log[1] !== 12'h109 ||
            alu_log.size() != 1 || err_cnt != 0) begin
            n_err++;
            $display("FAIL alu_op_log: writes=%0d alu=%0d errs=%0d expected 2 (007,109)/1/0",
                     wr_log.size(), alu_log.size(), err_cnt);
        end
        clear_logs();
        send_byte(8'hDD, 1);
        P_Data_RX  = 8'h04;
        Data_valid = 1'b1;
        @(posedge CLK);
        #1 Data_valid = 1'b0;
        n_vec++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h4 || CLK_EN !== 1'b1) begin
            n_err++;
            $display("FAIL alu_nop_start: ALU_EN=%b ALU_FUN=%h CLK_EN=%b expected 1/4/1",
                     ALU_EN, ALU_FUN, CLK_EN);
        end
        @(posedge CLK);
        #1 ALU_OUT_Valid = 1'b1;
        @(posedge CLK);
        #1 ALU_OUT_Valid = 1'b0;
        idle_cycles(2);
        n_vec++;
        if (wr_log.size() != 0 || alu_log.size() != 1 || Busy !== 1'b0 || err_cnt != 0) begin
            n_err++;
            $display("FAIL alu_nop_log: writes=%0d alu=%0d Busy=%b errs=%0d expected 0/1/0/0",
                     wr_log.size(), alu_log.size(), Busy, err_cnt);
        end
    endtask

    task automatic test_errors();
        int early;
        clear_logs();
        send_byte(8'h5A, 1);
        idle_cycles(2);
        n_vec++;
        if (err_cnt != 1 || wr_log.size() != 0 || rd_log.size() != 0 ||
            alu_log.size() != 0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL bad_opcode: errs=%0d strobes=%0d Busy=%b expected 1/0/0", err_cnt,
                     wr_log.size() + rd_log.size() + alu_log.size(), Busy);
        end
        clear_logs();
        early = 0;
        send_byte(8'hAA, 1);
        P_Data_RX  = 8'h03;
        Data_valid = 1'b1;
        @(posedge CLK);   // accept edge of the last byte
        #1 Data_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge CLK);
            #1;
            if (Frame_Err !== 1'b0) early++;
        end
        n_vec++;
        if (early != 0 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: early=%0d Busy=%b expected 0/1", early, Busy);
        end
        @(posedge CLK);
        #1;
        n_vec++;
        if (Frame_Err !== 1'b1 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_fire: Frame_Err=%b Busy=%b expected 1/0", Frame_Err, Busy);
        end
        idle_cycles(2);
        clear_logs();
        send_byte(8'hAA, 1);
        send_byte(8'h03, 1);
        send_byte(8'h7F, 1);
        idle_cycles(2);
        n_vec++;
        if (wr_log.size() != 1 || wr_log[0] !== 12'h37F || err_cnt != 0) begin
            n_err++;
            $display("FAIL write_after_timeout: writes=%0d first=%h errs=%0d expected 1/37f/0",
                     wr_log.size(), wr_log.size() ? wr_log[0] : 12'h0, err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] outs;
        clear_logs();
        send_byte(8'hEE, 1);
        send_byte(8'h02, 1);
        send_byte(8'h05, 1);
        P_Data_RX  = 8'h11;
        Data_valid = 1'b1;
        @(posedge CLK);
        #1 Data_valid = 1'b0;
        n_vec++;
        if (WrEn !== 1'b1 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_write: WrEn=%b Busy=%b expected 1/1", WrEn, Busy);
        end
        #2 RST = 1'b0;
        #1;
        outs = {ALU_EN, CLK_EN, WrEn, RdEn, ALU_FUN, Address, WrData, Busy, Frame_Err};
        n_vec++;
        if (outs !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h expected 0", outs);
        end
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        idle_cycles(1);
        n_vec++;
        if (Busy !== 1'b0 || err_cnt != 0) begin
            n_err++;
            $display("FAIL reset_silent: Busy=%b errs=%0d expected 0/0", Busy, err_cnt);
        end
        clear_logs();
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'hFF, 1);
        idle_cycles(2);
        n_vec++;
        if (wr_log.size() != 1 || wr_log[0] !== 12'h1FF || err_cnt != 0) begin
            n_err++;
            $display("FAIL write_after_reset: writes=%0d first=%h errs=%0d expected 1/1ff/0",
                     wr_log.size(), wr_log.size() ? wr_log[0] : 12'h0, err_cnt);
        end
    endtask

    task automatic test_exclusive();
        n_vec++;
        if (excl_viol != 0) begin
            n_err++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", excl_viol);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_write();
        test_read_long();
        test_burst();
        test_alu();
        test_errors();
        test_reset_mid_frame();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
